boot_copy_engine: RTL
=====================

Name: boot_copy_engine

Overview:
- Synthesizable ROM-to-RAM boot copier: after reset it moves a programmable block of words from instruction ROM into data RAM, then releases the core.
- Replaces the bench-driven force/release start-up copy with real RTL.
- Adds programmable base addresses and length, configurable ROM read latency, 1 word/cycle pipelined throughput, a running checksum and a core hold output.
- Sits between top_core, rom and ram; muxes onto the ram port while busy.

Parameters:
- AWIDTH, 14, byte-address width of ROM and RAM.
- XLEN, 32, data word width.
- LWIDTH, 12, width of the length field, in words.
- ROM_LAT, 1, ROM read latency in cycles; legal range 1..3.
- AUTO_START, 1, when 1 a copy self-starts on the first clock after reset release.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle copy request.
- src_base  in  AWIDTH  ROM byte start address; sampled on accepted start.
- dst_base  in  AWIDTH  RAM byte start address; sampled on accepted start.
- len_words  in  LWIDTH  number of words to copy; sampled on accepted start.
- rom_addr  out  AWIDTH  ROM read address.
- rom_data  in  XLEN  ROM read data; valid ROM_LAT cycles after rom_addr.
- ram_addr  out  AWIDTH  RAM write address.
- ram_wdata  out  XLEN  RAM write data.
- ram_we  out  3  RAM write enable; 3'b110 = word write, 3'b000 = idle.
- busy  out  1  copy in progress.
- done  out  1  last copy completed.
- core_hold  out  1  keeps the core statemachine halted.
- count  out  LWIDTH  words written in the current or last copy.
- checksum  out  XLEN  sum of written words, mod 2^XLEN.

Behaviour:
- Reset values: rom_addr=0, ram_addr=0, ram_wdata=0, ram_we=0, busy=0, done=0, count=0, checksum=0, core_hold=AUTO_START.
- Reset applies immediately, including mid-copy; any in-flight reads are discarded.
- FSM states:
  - IDLE -> RUN on accepted start, or on the internal auto-start.
  - RUN -> DRAIN when the last read has been issued.
  - DRAIN -> FIN when the last write has been performed.
  - FIN -> IDLE after one cycle.
- Auto-start: when AUTO_START=1, it fires once, on the first rising edge after rst deasserts, using the current port values.
- start is accepted only in IDLE. It is ignored in RUN, DRAIN and FIN; no queueing.
- On acceptance: sample src_base, dst_base and len_words; clear done, count and checksum; set busy the next cycle.
- Issue phase:
  - Start accepted at edge E0; cycle 1 is the cycle after E0.
  - Read k (k = 0..N-1) is issued in cycle 1+k with rom_addr = src_base + 4k.
  - Reads are one per cycle, no bubbles.
- Write phase:
  - rom_data is captured ROM_LAT cycles after its read was issued.
  - ram_we=3'b110 during cycle 2+k+ROM_LAT with ram_addr = dst_base + 4k and ram_wdata = word k.
  - ram_we is otherwise 3'b000.
- Per-word counters: count and checksum update at the end of each write cycle; checksum += word k.
- Completion: done rises in cycle N+2+ROM_LAT and busy falls in the same cycle. done stays high until the next accepted start.
- Address arithmetic wraps modulo 2^AWIDTH on both the source and destination sides.
- len_words=0: no reads or writes; busy is high for 1 cycle, then done.
- core_hold: high from reset until the first done when AUTO_START=1. Also high whenever busy=1.
- ram_addr and rom_addr hold their last values when idle.

Test Plan:
1. Reset: assert rst mid-cycle, AUTO_START=1 -> all outputs 0 immediately except core_hold=1.
2. Basic copy: AUTO_START=0, ROM_LAT=1; ROM[0x800..0x80C] = 0x11, 0x22, 0x33, 0x44; start with src=0x800, dst=0x000, len=4 at E0 -> ram_we=3'b110 in cycles 3..6 at addr 0x0, 0x4, 0x8, 0xC with data 0x11..0x44; done=1 in cycle 7; count=4; checksum=0xAA; busy high in cycles 1..6.
3. Zero length and ignored start: start len=0 -> no ram_we, done one cycle after busy; then start again during a len=4 copy at cycle 3 -> ignored, exactly 4 writes, second start ineffective.
4. Wrap and latency: ROM_LAT=3, dst=0x3FFC, src=0x3FFC, len=2 -> reads at 0x3FFC, 0x0000; writes at 0x3FFC then 0x0000 in cycles 5 and 6; done in cycle 7.
5. Reset mid-copy: len=8, assert rst after the 2nd write -> ram_we=0 at once, busy=0, count=0; after release with AUTO_START=0 there are no further writes and done stays 0.
6. Auto-start: AUTO_START=1, ports src=0x800, dst=0, len=4 -> copy begins at the first edge after rst release; core_hold stays 1 until done; checksum matches the ROM word sum.

Source files
------------

// File: rtl/boot_copy_engine.sv
// Boot copier: streams a block of words from instruction ROM into data RAM after reset,
// one word per cycle, keeping a running checksum and holding the core until the copy is done.
module boot_copy_engine #(
    parameter int unsigned AWIDTH     = 14,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LWIDTH     = 12,
    parameter int unsigned ROM_LAT    = 1,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] src_base,
    input  logic [AWIDTH-1:0] dst_base,
    input  logic [LWIDTH-1:0] len_words,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_data,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [XLEN-1:0]   ram_wdata,
    output logic [2:0]        ram_we,
    output logic              busy,
    output logic              done,
    output logic              core_hold,
    output logic [LWIDTH-1:0] count,
    output logic [XLEN-1:0]   checksum
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    localparam logic [2:0]        WeWord = 3'b110;
    localparam logic [AWIDTH-1:0] Step   = AWIDTH'(4);

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [AWIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]     ram_wdata_q, ram_wdata_d;
    logic [XLEN-1:0]     checksum_q, checksum_d;
    logic [2:0]          ram_we_q, ram_we_d;
    logic [LWIDTH-1:0]   len_q, len_d;
    logic [LWIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LWIDTH-1:0]   count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hold_q, hold_d;
    logic                auto_pend_q, auto_pend_d;
    // One bit per ROM latency stage; the top bit marks a cycle whose rom_data must be captured.
    logic [ROM_LAT-1:0]  vld_q, vld_d;

    logic accept, issue, capture, wr_now, last_wr;

    // Next-state logic: read issue, write capture, per-word accounting and sequencing
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        wr_addr_d   = wr_addr_q;
        ram_wdata_d = ram_wdata_q;
        checksum_d  = checksum_q;
        ram_we_d    = 3'b000;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = done_q;
        hold_d      = hold_q;
        // The auto-start request only survives the first edge after reset.
        auto_pend_d = 1'b0;

        accept  = (state_q == StIdle) && (start || auto_pend_q);
        issue   = (state_q == StRun) && (len_q != '0);
        capture = vld_q[ROM_LAT-1];
        wr_now  = (ram_we_q == WeWord);
        last_wr = wr_now && ((count_q + LWIDTH'(1)) == len_q);

        vld_d[0] = issue;
        for (int unsigned j = 1; j < ROM_LAT; j++) begin
            vld_d[j] = vld_q[j-1];
        end

        if (capture) begin
            ram_we_d    = WeWord;
            ram_wdata_d = rom_data;
            ram_addr_d  = wr_addr_q;
            wr_addr_d   = wr_addr_q + Step;
        end

        if (wr_now) begin
            count_d    = count_q + LWIDTH'(1);
            checksum_d = checksum_q + ram_wdata_q;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    len_d      = len_words;
                    rd_cnt_d   = '0;
                    wr_addr_d  = dst_base;
                    done_d     = 1'b0;
                    count_d    = '0;
                    checksum_d = '0;
                    busy_d     = 1'b1;
                    state_d    = StRun;
                    if (len_words != '0) begin
                        rom_addr_d = src_base;
                    end
                end
            end
            StRun: begin
                if (len_q == '0) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    hold_d  = 1'b0;
                end else if ((rd_cnt_q + LWIDTH'(1)) == len_q) begin
                    state_d = StDrain;
                end else begin
                    rom_addr_d = rom_addr_q + Step;
                    rd_cnt_d   = rd_cnt_q + LWIDTH'(1);
                end
            end
            StDrain: begin
                if (last_wr) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    hold_d  = 1'b0;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            wr_addr_q   <= '0;
            ram_wdata_q <= '0;
            checksum_q  <= '0;
            ram_we_q    <= 3'b000;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= AUTO_START;
            auto_pend_q <= AUTO_START;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            wr_addr_q   <= wr_addr_d;
            ram_wdata_q <= ram_wdata_d;
            checksum_q  <= checksum_d;
            ram_we_q    <= ram_we_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
            auto_pend_q <= auto_pend_d;
            vld_q       <= vld_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign checksum  = checksum_q;
    assign core_hold = hold_q | busy_q;

endmodule
